// File: rtl/csa_slice_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : csa_slice_scheduler                                          |
// | Description : Shared multi-cycle carry-select adder. Two requesters are    |
// |               arbitrated round-robin; the winner's operands are added one  |
// |               SLICE-bit slice per cycle, and the sum, carry-out and signed |
// |               overflow are returned tagged with the requester ID.          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module csa_slice_scheduler #(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic             cin0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    input  logic             cin1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             busy,
    output logic             done,
    output logic             done_id,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int c_NSLICE = WIDTH / SLICE;
    localparam int c_KW     = (c_NSLICE > 1) ? $clog2(c_NSLICE) : 1;
    localparam logic [c_KW-1:0] c_K_LAST = c_KW'(c_NSLICE - 1);

    localparam logic [1:0] c_S_IDLE = 2'd0;
    localparam logic [1:0] c_S_RUN  = 2'd1;
    localparam logic [1:0] c_S_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_op_a;
    logic [WIDTH-1:0] r_op_b;
    logic [WIDTH-1:0] r_res;
    logic             r_carry;
    logic [c_KW-1:0]  r_k;
    logic             r_id;
    logic             r_last;
    logic             r_gnt0;
    logic             r_gnt1;
    logic             r_busy;
    logic             r_done;
    logic             r_done_id;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;

    logic [SLICE-1:0] w_sa;
    logic [SLICE-1:0] w_sb;
    logic [SLICE:0]   w_sum0;
    logic [SLICE:0]   w_sum1;
    logic [SLICE:0]   w_sel;
    logic [WIDTH-1:0] w_res_next;
    logic             w_c_msb;
    logic             w_any;
    logic             w_win;

    // Slice datapath: both carry-in candidates precomputed, registered carry selects.
    always_comb begin
        w_sa       = r_op_a[int'(r_k)*SLICE +: SLICE];
        w_sb       = r_op_b[int'(r_k)*SLICE +: SLICE];
        w_sum0     = {1'b0, w_sa} + {1'b0, w_sb};
        w_sum1     = {1'b0, w_sa} + {1'b0, w_sb} + {{SLICE{1'b0}}, 1'b1};
        w_sel      = r_carry ? w_sum1 : w_sum0;
        w_res_next = r_res;
        w_res_next[int'(r_k)*SLICE +: SLICE] = w_sel[SLICE-1:0];
        // Carry into the top bit recovered from its sum bit; only used on the MSB slice.
        w_c_msb    = w_sa[SLICE-1] ^ w_sb[SLICE-1] ^ w_sel[SLICE-1];
        // Round-robin: a lone requester wins; on a tie the one not served last wins.
        w_any      = req0 | req1;
        w_win      = req1 & (~req0 | ~r_last);
    end

    // Control FSM, operand/result registers and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_S_IDLE;
            r_op_a    <= '0;
            r_op_b    <= '0;
            r_res     <= '0;
            r_carry   <= 1'b0;
            r_k       <= '0;
            r_id      <= 1'b0;
            r_last    <= 1'b1;
            r_gnt0    <= 1'b0;
            r_gnt1    <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_done_id <= 1'b0;
            r_sum     <= '0;
            r_cout    <= 1'b0;
            r_ovf     <= 1'b0;
        end else begin
            r_gnt0 <= 1'b0;
            r_gnt1 <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                c_S_IDLE: begin
                    if (w_any) begin
                        r_op_a  <= w_win ? a1 : a0;
                        r_op_b  <= w_win ? b1 : b0;
                        r_carry <= w_win ? cin1 : cin0;
                        r_k     <= '0;
                        r_id    <= w_win;
                        r_last  <= w_win;
                        r_gnt0  <= ~w_win;
                        r_gnt1  <= w_win;
                        r_busy  <= 1'b1;
                        r_state <= c_S_RUN;
                    end
                end
                c_S_RUN: begin
                    r_res   <= w_res_next;
                    r_carry <= w_sel[SLICE];
                    if (r_k == c_K_LAST) begin
                        r_k       <= '0;
                        r_sum     <= w_res_next;
                        r_cout    <= w_sel[SLICE];
                        r_ovf     <= w_c_msb ^ w_sel[SLICE];
                        r_done_id <= r_id;
                        r_done    <= 1'b1;
                        r_state   <= c_S_DONE;
                    end else begin
                        r_k <= r_k + c_KW'(1);
                    end
                end
                c_S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= c_S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= c_S_IDLE;
                end
            endcase
        end
    end

    assign gnt0    = r_gnt0;
    assign gnt1    = r_gnt1;
    assign busy    = r_busy;
    assign done    = r_done;
    assign done_id = r_done_id;
    assign sum     = r_sum;
    assign cout    = r_cout;
    assign ovf     = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_csa_slice_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_csa_slice_scheduler                                       |
// | Description : Self-checking bench for csa_slice_scheduler: vector table,   |
// |               random operands against a reference sum, arbitration order,  |
// |               reset abort and result hold, with a result scoreboard.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_csa_slice_scheduler;

    localparam int WIDTH = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             req0, req1, cin0, cin1;
    logic [WIDTH-1:0] a0, b0, a1, b1;
    logic             gnt0, gnt1, busy, done, done_id, cout, ovf;
    logic [WIDTH-1:0] sum;

    typedef struct {
        logic             id;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             cin;
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
    } vec_t;

    typedef struct {
        logic             id;
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
    } exp_t;

    exp_t sb_q[$];
    vec_t tbl[0:6];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    csa_slice_scheduler #(.WIDTH(WIDTH), .SLICE(4)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .a0(a0), .b0(b0), .cin0(cin0),
        .req1(req1), .a1(a1), .b1(b1), .cin1(cin1),
        .gnt0(gnt0), .gnt1(gnt1), .busy(busy), .done(done),
        .done_id(done_id), .sum(sum), .cout(cout), .ovf(ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: every done pulse is matched against the oldest pending expectation.
    always @(negedge clk) begin : mon
        exp_t e;
        if (done === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_done", 32'(done), 32'd0);
            end else begin
                e = sb_q.pop_front();
                chk("done_id", 32'(done_id), 32'(e.id));
                chk("sum",     32'(sum),     32'(e.sum));
                chk("cout",    32'(cout),    32'(e.cout));
                chk("ovf",     32'(ovf),     32'(e.ovf));
            end
        end
    end

    // One complete transaction from a single requester, with grant/done timing checks.
    task automatic do_req(input logic id, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic c, input exp_t e);
        bit seen;
        int lat;
        seen = 1'b0;
        lat  = 0;
        if (id) begin
            req1 = 1'b1; a1 = a; b1 = b; cin1 = c;
        end else begin
            req0 = 1'b1; a0 = a; b0 = b; cin0 = c;
        end
        sb_q.push_back(e);
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if ((id ? gnt1 : gnt0) === 1'b1) begin
                seen = 1'b1;
                chk("gnt_latency", 32'(t), 32'd0);
                break;
            end
        end
        chk("gnt_seen", 32'(seen), 32'd1);
        chk("gnt_other", 32'(id ? gnt0 : gnt1), 32'd0);
        chk("busy_run", 32'(busy), 32'd1);
        req0 = 1'b0;
        req1 = 1'b0;
        for (int d = 1; d <= 20; d++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                lat = d;
                break;
            end
        end
        chk("done_latency", 32'(lat), 32'd4);
        @(negedge clk);
        chk("busy_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t             e;
        exp_t             last_e;
        logic [WIDTH-1:0] ra, rb;
        logic             rc, rid;
        logic [WIDTH:0]   full;
        logic             exp_ids[0:3];
        bit               seen;
        int               prev;

        // id, a, b, cin, sum, cout, ovf
        tbl[0] = '{1'b0, 16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        tbl[2] = '{1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0};
        tbl[3] = '{1'b1, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        tbl[4] = '{1'b0, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
        tbl[5] = '{1'b1, 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        tbl[6] = '{1'b0, 16'h0F0F, 16'hF0F0, 1'b1, 16'h0000, 1'b1, 1'b0};
        exp_ids[0] = 1'b0; exp_ids[1] = 1'b1; exp_ids[2] = 1'b0; exp_ids[3] = 1'b1;
        prev = 0;

        rst = 1'b1; req0 = 1'b0; req1 = 1'b0; cin0 = 1'b0; cin1 = 1'b0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        repeat (3) @(negedge clk);
        chk("rst_gnt0", 32'(gnt0), 32'd0);
        chk("rst_gnt1", 32'(gnt1), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_done_id", 32'(done_id), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_busy", 32'(busy), 32'd0);

        // Directed vectors.
        for (int i = 0; i < 7; i++) begin
            e = '{tbl[i].id, tbl[i].sum, tbl[i].cout, tbl[i].ovf};
            do_req(tbl[i].id, tbl[i].a, tbl[i].b, tbl[i].cin, e);
            last_e = e;
        end

        // Random operands against a reference full-width sum.
        for (int i = 0; i < 6; i++) begin
            ra   = 16'($urandom);
            rb   = 16'($urandom);
            rc   = 1'($urandom);
            rid  = 1'($urandom);
            full = {1'b0, ra} + {1'b0, rb} + {{WIDTH{1'b0}}, rc};
            e    = '{rid, full[WIDTH-1:0], full[WIDTH],
                     (ra[WIDTH-1] == rb[WIDTH-1]) && (full[WIDTH-1] != ra[WIDTH-1])};
            do_req(rid, ra, rb, rc, e);
            last_e = e;
        end

        // Results hold while idle.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("hold_sum", 32'(sum), 32'(last_e.sum));
            chk("hold_cout", 32'(cout), 32'(last_e.cout));
            chk("hold_ovf", 32'(ovf), 32'(last_e.ovf));
            chk("hold_done_id", 32'(done_id), 32'(last_e.id));
            chk("hold_quiet", 32'(gnt0 | gnt1 | done), 32'd0);
        end

        // Arbitration: both requesting out of reset, then both re-raised.
        rst  = 1'b1;
        req0 = 1'b1; a0 = 16'h4000; b0 = 16'h4000; cin0 = 1'b0;
        req1 = 1'b1; a1 = 16'hABCD; b1 = 16'h1111; cin1 = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        sb_q.push_back('{1'b0, 16'h8000, 1'b0, 1'b1});
        sb_q.push_back('{1'b1, 16'hBCDF, 1'b0, 1'b0});
        for (int g = 0; g < 4; g++) begin
            seen = 1'b0;
            for (int t = 0; t < 30; t++) begin
                @(negedge clk);
                if ((gnt0 | gnt1) === 1'b1) begin
                    seen = 1'b1;
                    break;
                end
            end
            chk("arb_gnt_seen", 32'(seen), 32'd1);
            chk("arb_order", 32'(gnt1), 32'(exp_ids[g]));
            if (g > 0) chk("arb_spacing", 32'(cyc - prev), 32'd6);
            prev = cyc;
            if (gnt0 === 1'b1) req0 = 1'b0;
            if (gnt1 === 1'b1) req1 = 1'b0;
            if (g == 1) begin
                req0 = 1'b1;
                req1 = 1'b1;
                sb_q.push_back('{1'b0, 16'h8000, 1'b0, 1'b1});
                sb_q.push_back('{1'b1, 16'hBCDF, 1'b0, 1'b0});
            end
        end
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (sb_q.size() == 0) break;
        end
        repeat (2) @(negedge clk);
        chk("arb_drain", 32'(sb_q.size()), 32'd0);

        // Reset two cycles after a grant aborts the transaction.
        req0 = 1'b1; a0 = 16'h1111; b0 = 16'h2222; cin0 = 1'b0;
        seen = 1'b0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (gnt0 === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        chk("abort_gnt_seen", 32'(seen), 32'd1);
        req0 = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("abort_done", 32'(done), 32'd0);
            chk("abort_busy", 32'(busy), 32'd0);
            chk("abort_sum", 32'(sum), 32'd0);
        end
        chk("abort_cout", 32'(cout), 32'd0);
        chk("abort_ovf", 32'(ovf), 32'd0);

        e = '{1'b1, 16'h1111, 1'b0, 1'b0};
        do_req(1'b1, 16'h0101, 16'h1010, 1'b0, e);

        chk("final_queue_empty", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
